// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths, register map and requester indices
package rf_pkg;

    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NREG = 6;

    localparam logic [AW-1:0] REG_A  = 3'd0;
    localparam logic [AW-1:0] REG_X  = 3'd1;
    localparam logic [AW-1:0] REG_Y  = 3'd2;
    localparam logic [AW-1:0] REG_Z  = 3'd3;
    localparam logic [AW-1:0] REG_SP = 3'd4;
    localparam logic [AW-1:0] REG_FP = 3'd5;

    localparam int REQ_ALU   = 0;
    localparam int REQ_LOAD  = 1;
    localparam int REQ_STACK = 2;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant and rotating priority pointer
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;

    // Search starts at ptr and wraps; the first requester seen wins.
    always_comb begin
        int idx;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                gidx       = PW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the register-file write port among write-back sources and forwards in-flight data
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = rf_pkg::DW,
    parameter int AW   = rf_pkg::AW,
    parameter int NREG = rf_pkg::NREG
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [AW*NREQ-1:0] req_addr,
    input  logic [DW*NREQ-1:0] req_data,
    output logic [AW-1:0]      rf_write_addr,
    output logic [DW-1:0]      rf_write_data,
    output logic               rf_write_enable,
    input  logic [AW-1:0]      rd_addr1,
    input  logic [AW-1:0]      rd_addr2,
    input  logic [DW-1:0]      rf_out_1,
    input  logic [DW-1:0]      rf_out_2,
    output logic [DW-1:0]      fwd_out_1,
    output logic [DW-1:0]      fwd_out_2,
    output logic               addr_err,
    input  logic               err_clr
);

    localparam logic [AW:0] NREG_LIM = (AW + 1)'(NREG);

    function automatic logic addr_legal(input logic [AW-1:0] a);
        return {1'b0, a} < NREG_LIM;
    endfunction

    logic [NREQ-1:0] grant;
    logic            any_grant;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;

    rr_arbiter #(
        .N(NREQ)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .advance(any_grant),
        .grant  (grant)
    );

    // The arbiter's grant is purely combinational; hide it while reset is held.
    assign req_ready = rst_n ? grant : '0;
    assign any_grant = |grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[AW*i +: AW];
                sel_data = sel_data | req_data[DW*i +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= any_grant;
            wb_addr  <= sel_addr;
            wb_data  <= sel_data;
        end
    end

    // Captured at grant so the flag is visible in the same cycle the bad write is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if (any_grant && !addr_legal(sel_addr)) begin
            addr_err <= 1'b1;
        end else if (err_clr) begin
            addr_err <= 1'b0;
        end
    end

    assign rf_write_enable = wb_valid && addr_legal(wb_addr);
    assign rf_write_addr   = wb_addr;
    assign rf_write_data   = wb_data;

    assign fwd_out_1 = (rf_write_enable && (rd_addr1 == wb_addr)) ? wb_data : rf_out_1;
    assign fwd_out_2 = (rf_write_enable && (rd_addr2 == wb_addr)) ? wb_data : rf_out_2;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - scoreboard bench for rf_write_arbiter with directed vectors
module tb_rf_write_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req_valid;
    logic [2:0] req_ready;
    logic [8:0] req_addr;
    logic [23:0] req_data;
    logic [2:0] rf_write_addr;
    logic [7:0] rf_write_data;
    logic       rf_write_enable;
    logic [2:0] rd_addr1;
    logic [2:0] rd_addr2;
    logic [7:0] rf_out_1;
    logic [7:0] rf_out_2;
    logic [7:0] fwd_out_1;
    logic [7:0] fwd_out_2;
    logic       addr_err;
    logic       err_clr;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .NREQ(3), .DW(8), .AW(3), .NREG(6)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .rf_write_addr  (rf_write_addr),
        .rf_write_data  (rf_write_data),
        .rf_write_enable(rf_write_enable),
        .rd_addr1       (rd_addr1),
        .rd_addr2       (rd_addr2),
        .rf_out_1       (rf_out_1),
        .rf_out_2       (rf_out_2),
        .fwd_out_1      (fwd_out_1),
        .fwd_out_2      (fwd_out_2),
        .addr_err       (addr_err),
        .err_clr        (err_clr)
    );

    // Behavioural register file fed by the DUT write port.
    logic [7:0] regs [8] = '{default: 8'h00};
    always @(posedge clk) begin
        if (rf_write_enable) regs[rf_write_addr] <= rf_write_data;
    end
    assign rf_out_1 = regs[rd_addr1];
    assign rf_out_2 = regs[rd_addr2];

    typedef enum int {S_READY, S_WE, S_WADDR, S_WDATA, S_FWD1, S_FWD2, S_ERR} sig_e;
    typedef struct {
        int         cyc;
        sig_e       sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(input sig_e s);
        case (s)
            S_READY: return {5'b0, req_ready};
            S_WE:    return {7'b0, rf_write_enable};
            S_WADDR: return {5'b0, rf_write_addr};
            S_WDATA: return rf_write_data;
            S_FWD1:  return fwd_out_1;
            S_FWD2:  return fwd_out_2;
            S_ERR:   return {7'b0, addr_err};
            default: return 8'h00;
        endcase
    endfunction

    task automatic expect_at(input int off, input sig_e s, input logic [7:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + off;
        e.sig  = s;
        e.val  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: sample away from the rising edge and retire every expectation due this cycle.
    always @(negedge clk) begin
        logic [7:0] act;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                act = actual(exp_q[i].sig);
                n_checks++;
                if (act !== exp_q[i].val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d actual=%h required=%h", exp_q[i].name, cyc, act, exp_q[i].val);
                end
                exp_q.delete(i);
            end else if (exp_q[i].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s stale expectation for cyc=%0d at cyc=%0d", exp_q[i].name, exp_q[i].cyc, cyc);
                exp_q.delete(i);
            end
        end
    end

    task automatic drive(input logic [2:0] v, input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                         input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [2:0] fair_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [2:0] fair_a [6] = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd3};
    logic [7:0] fair_d [6] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33};
    logic [2:0] pair_g [3] = '{3'b010, 3'b100, 3'b010};
    logic [7:0] pair_d [3] = '{8'h22, 8'h33, 8'h22};

    initial begin
        rst_n    = 1'b0;
        err_clr  = 1'b0;
        rd_addr1 = 3'd0;
        rd_addr2 = 3'd0;
        drive(3'b111, 3'd0, 3'd1, 3'd3, 8'h11, 8'h22, 8'h33);
        tick();
        expect_at(0, S_READY, 8'h00, "rst_ready");
        expect_at(0, S_WE,    8'h00, "rst_we");
        expect_at(0, S_WADDR, 8'h00, "rst_waddr");
        expect_at(0, S_WDATA, 8'h00, "rst_wdata");
        expect_at(0, S_ERR,   8'h00, "rst_err");
        tick();

        // Single write, grant in the release cycle.
        rst_n = 1'b1;
        drive(3'b001, 3'd2, 3'd0, 3'd0, 8'h5A, 8'h00, 8'h00);
        rd_addr1 = 3'd2;
        expect_at(0, S_READY, 8'h01, "single_ready");
        expect_at(0, S_FWD1,  8'h00, "single_fwd_pre");
        expect_at(1, S_WE,    8'h01, "single_we");
        expect_at(1, S_WADDR, 8'h02, "single_waddr");
        expect_at(1, S_WDATA, 8'h5A, "single_wdata");
        expect_at(1, S_FWD1,  8'h5A, "single_fwd");
        tick();
        drive(3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
        tick();
        expect_at(0, S_FWD1, 8'h5A, "single_committed");
        expect_at(0, S_WE,   8'h00, "single_idle_we");

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Full load: strict rotation.
        drive(3'b111, 3'd0, 3'd1, 3'd3, 8'h11, 8'h22, 8'h33);
        for (int k = 0; k < 6; k++) begin
            expect_at(0, S_READY, {5'b0, fair_g[k]}, "fair_ready");
            expect_at(1, S_WADDR, {5'b0, fair_a[k]}, "fair_waddr");
            expect_at(1, S_WDATA, fair_d[k], "fair_wdata");
            tick();
        end
        // Only requesters 1 and 2, pointer back at 0.
        drive(3'b110, 3'd0, 3'd1, 3'd3, 8'h11, 8'h22, 8'h33);
        for (int k = 0; k < 3; k++) begin
            expect_at(0, S_READY, {5'b0, pair_g[k]}, "pair_ready");
            expect_at(1, S_WDATA, pair_d[k], "pair_wdata");
            tick();
        end
        drive(3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
        tick();

        // Illegal address from requester 1.
        drive(3'b010, 3'd0, 3'd6, 3'd0, 8'h00, 8'hFF, 8'h00);
        expect_at(0, S_READY, 8'h02, "illegal_ready");
        expect_at(0, S_ERR,   8'h00, "illegal_err_pre");
        expect_at(1, S_WE,    8'h00, "illegal_we");
        expect_at(1, S_WADDR, 8'h06, "illegal_waddr");
        expect_at(1, S_WDATA, 8'hFF, "illegal_wdata");
        expect_at(1, S_ERR,   8'h01, "illegal_err_set");
        tick();
        drive(3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
        tick();
        err_clr = 1'b1;
        expect_at(0, S_ERR, 8'h01, "err_sticky");
        expect_at(1, S_ERR, 8'h00, "err_cleared");
        tick();
        err_clr = 1'b0;
        tick();
        // Clear coincident with a new illegal grant: set wins.
        err_clr = 1'b1;
        drive(3'b100, 3'd0, 3'd0, 3'd7, 8'h00, 8'h00, 8'hEE);
        expect_at(0, S_READY, 8'h04, "setwin_ready");
        expect_at(1, S_ERR,   8'h01, "setwin_err");
        expect_at(1, S_WE,    8'h00, "setwin_we");
        tick();
        err_clr = 1'b0;
        drive(3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
        expect_at(1, S_ERR, 8'h01, "setwin_hold");
        tick();
        err_clr = 1'b1;
        expect_at(1, S_ERR, 8'h00, "err_cleared2");
        tick();
        err_clr = 1'b0;

        // Back-to-back writes to SP.
        drive(3'b001, 3'd4, 3'd0, 3'd0, 8'h10, 8'h00, 8'h00);
        rd_addr1 = 3'd4;
        expect_at(0, S_READY, 8'h01, "b2b_ready0");
        tick();
        drive(3'b100, 3'd0, 3'd0, 3'd4, 8'h00, 8'h00, 8'h20);
        expect_at(0, S_READY, 8'h04, "b2b_ready2");
        expect_at(0, S_WE,    8'h01, "b2b_we1");
        expect_at(0, S_WADDR, 8'h04, "b2b_waddr1");
        expect_at(0, S_WDATA, 8'h10, "b2b_wdata1");
        expect_at(0, S_FWD1,  8'h10, "b2b_fwd1");
        tick();
        drive(3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
        expect_at(0, S_WE,    8'h01, "b2b_we2");
        expect_at(0, S_WDATA, 8'h20, "b2b_wdata2");
        expect_at(0, S_FWD1,  8'h20, "b2b_fwd2");
        tick();
        expect_at(0, S_WE,   8'h00, "b2b_idle_we");
        expect_at(0, S_FWD1, 8'h20, "b2b_committed");
        tick();

        // Both read ports on the in-flight address, then port 2 elsewhere.
        drive(3'b001, 3'd3, 3'd0, 3'd0, 8'h44, 8'h00, 8'h00);
        rd_addr1 = 3'd3;
        rd_addr2 = 3'd3;
        expect_at(0, S_READY, 8'h01, "dual_ready");
        tick();
        drive(3'b001, 3'd3, 3'd0, 3'd0, 8'h55, 8'h00, 8'h00);
        expect_at(0, S_READY, 8'h01, "dual_ready2");
        expect_at(0, S_FWD1,  8'h44, "dual_fwd1");
        expect_at(0, S_FWD2,  8'h44, "dual_fwd2");
        tick();
        drive(3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
        rd_addr2 = 3'd5;
        expect_at(0, S_FWD1, 8'h55, "dual_fwd1_new");
        expect_at(0, S_FWD2, 8'h00, "dual_fwd2_raw");
        tick();

        // Reset while a write to X is in flight.
        drive(3'b001, 3'd1, 3'd0, 3'd0, 8'h33, 8'h00, 8'h00);
        rd_addr1 = 3'd1;
        rd_addr2 = 3'd1;
        expect_at(0, S_READY, 8'h01, "midrst_grant");
        expect_at(0, S_FWD1,  8'h22, "midrst_x_before");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        tick();
        expect_at(0, S_WE,    8'h00, "midrst_we");
        expect_at(0, S_READY, 8'h00, "midrst_ready");
        expect_at(0, S_FWD1,  8'h22, "midrst_x_held");
        tick();
        rst_n = 1'b1;
        drive(3'b111, 3'd0, 3'd1, 3'd3, 8'h11, 8'h22, 8'h33);
        expect_at(0, S_READY, 8'h01, "midrst_ptr0");
        tick();
        drive(3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
        expect_at(0, S_WE,    8'h01, "post_rst_we");
        expect_at(0, S_WADDR, 8'h00, "post_rst_waddr");
        expect_at(0, S_FWD1,  8'h22, "midrst_x_after");
        tick();
        tick();

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover_expectations actual=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
